// File: rtl/pc_fetch_if.sv
// Fetch-unit bundle: decoder/ALU control into the fetch unit, and the imem
// address plus program-counter status back out.
// Optional macro FETCH_PERF_EN adds the perf_retired/perf_redirects counters.
interface pc_fetch_if #(
  parameter int ADDR_W = 12
);
  logic              jp;
  logic              jpr;
  logic              br_ne;
  logic              br_lt;
  logic              rst_sel;
  logic              cmp_ne;
  logic              cmp_lt;
  logic              rstatus_nz;
  logic [26:0]       target;
  logic [16:0]       imm;
  logic [31:0]       rd_value;
  logic              stall;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_en;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       pc_plus1;
  logic              inst_valid;
  logic              commit;
`ifdef FETCH_PERF_EN
  logic [31:0]       perf_retired;
  logic [31:0]       perf_redirects;

  modport master (
    output jp, jpr, br_ne, br_lt, rst_sel, cmp_ne, cmp_lt, rstatus_nz,
           target, imm, rd_value, stall,
    input  imem_addr, imem_en, pc, pc_plus1, inst_valid, commit,
           perf_retired, perf_redirects
  );
  modport slave (
    input  jp, jpr, br_ne, br_lt, rst_sel, cmp_ne, cmp_lt, rstatus_nz,
           target, imm, rd_value, stall,
    output imem_addr, imem_en, pc, pc_plus1, inst_valid, commit,
           perf_retired, perf_redirects
  );
`else
  modport master (
    output jp, jpr, br_ne, br_lt, rst_sel, cmp_ne, cmp_lt, rstatus_nz,
           target, imm, rd_value, stall,
    input  imem_addr, imem_en, pc, pc_plus1, inst_valid, commit
  );
  modport slave (
    input  jp, jpr, br_ne, br_lt, rst_sel, cmp_ne, cmp_lt, rstatus_nz,
           target, imm, rd_value, stall,
    output imem_addr, imem_en, pc, pc_plus1, inst_valid, commit
  );
`endif
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter / fetch unit: BOOT -> RUN <-> STALL, next-PC selection
// from decoder jump/branch bits and ALU flags, drives a registered-read imem.
// Optional macro FETCH_PERF_EN adds saturating retired/redirect counters.
module pc_fetch_unit #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clock_i,
  input  logic         reset_ni,
  pc_fetch_if.slave    fetch_if
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] imm_ext;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] next_pc;
  logic              br_taken;
  logic              advance;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_en;
  logic              inst_valid;
  logic              commit;

  // Sign-extend (or truncate) the branch offset to PC width; wraps naturally.
  assign imm_ext  = ADDR_W'($signed(fetch_if.imm));
  assign pc_inc   = pc_q + ADDR_W'(1);
  assign br_tgt   = pc_inc + imm_ext;
  assign br_taken = (fetch_if.br_ne & fetch_if.cmp_ne) |
                    (fetch_if.br_lt & fetch_if.cmp_lt);

  // The instruction on imem_q retires whenever we are past boot and not stalled.
  assign advance  = (state_q != BOOT) && !fetch_if.stall;

  // Next-PC priority: jr, then j/jal/bex, then taken branch, then sequential.
  always_comb begin
    next_pc = pc_inc;
    if (fetch_if.jpr) begin
      next_pc = fetch_if.rd_value[ADDR_W-1:0];
    end else if (fetch_if.jp) begin
      if (!fetch_if.rst_sel || fetch_if.rstatus_nz) begin
        next_pc = fetch_if.target[ADDR_W-1:0];
      end
    end else if (br_taken) begin
      next_pc = br_tgt;
    end
  end

  assign pc_d = advance ? next_pc : pc_q;

  // State and PC registers with synchronous active-low reset.
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state: one boot cycle, then RUN/STALL follow the stall input.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = fetch_if.stall ? STALL : RUN;
      STALL:   state_d = fetch_if.stall ? STALL : RUN;
      default: state_d = BOOT;
    endcase
  end

  // Outputs; reset forces the quiet boot values immediately, even mid-stall.
  always_comb begin
    imem_en    = 1'b0;
    inst_valid = 1'b0;
    commit     = 1'b0;
    imem_addr  = pc_q;
    if (!reset_ni) begin
      imem_addr = RESET_PC;
    end else begin
      case (state_q)
        BOOT: begin
          imem_en = 1'b1;
        end
        RUN, STALL: begin
          imem_en    = 1'b1;
          inst_valid = 1'b1;
          commit     = !fetch_if.stall;
          // Present next_pc on commit so imem_q lines up with the new pc.
          imem_addr  = fetch_if.stall ? pc_q : next_pc;
        end
        default: ;
      endcase
    end
  end

  assign fetch_if.imem_addr  = imem_addr;
  assign fetch_if.imem_en    = imem_en;
  assign fetch_if.pc         = pc_q;
  assign fetch_if.pc_plus1   = 32'(pc_inc);
  assign fetch_if.inst_valid = inst_valid;
  assign fetch_if.commit     = commit;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_retired_q;
  logic [31:0] perf_redirects_q;

  // Saturating counters of retired instructions and non-sequential commits.
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      perf_retired_q   <= '0;
      perf_redirects_q <= '0;
    end else if (commit) begin
      if (perf_retired_q != '1) begin
        perf_retired_q <= perf_retired_q + 32'd1;
      end
      if ((next_pc != pc_inc) && (perf_redirects_q != '1)) begin
        perf_redirects_q <= perf_redirects_q + 32'd1;
      end
    end
  end

  assign fetch_if.perf_retired   = perf_retired_q;
  assign fetch_if.perf_redirects = perf_redirects_q;
`endif

endmodule
